// File: rtl/uart_ftw_rx.sv
// 8N1 UART receiver plus frame assembler: HEADER, FTW_BYTES payload bytes (MSB first)
// and an XOR checksum byte; a validated frame updates ftw with a one-cycle ftw_valid.
module uart_ftw_rx #(
  parameter int                     CLKS_PER_BIT = 87,
  parameter int                     FTW_BYTES    = 4,
  parameter logic [7:0]             HEADER       = 8'hA5,
  parameter int                     TIMEOUT_BITS = 20,
  parameter logic [8*FTW_BYTES-1:0] FTW_RESET    = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  output logic [8*FTW_BYTES-1:0]   ftw,
  output logic                     ftw_valid,
  output logic                     frame_err,
  output logic                     busy
);

  localparam int W        = 8 * FTW_BYTES;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam int HALF     = CLKS_PER_BIT / 2;
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW       = $clog2(TO_LIMIT + 1);
  localparam int BCW      = $clog2(FTW_BYTES + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {AS_HUNT, AS_PAYLOAD, AS_CHECK} as_state_t;

  // Synchronizer flops reset high so a reset never manufactures a start edge.
  logic rx_meta, rx_sync, rx_prev;

  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            byte_stb_q, byte_stb_d;
  logic            stop_err_q, stop_err_d;

  as_state_t       as_state_q, as_state_d;
  logic [BCW-1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]      xor_acc_q, xor_acc_d;
  logic [W-1:0]    shadow_q, shadow_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [W-1:0]    ftw_d;
  logic            ftw_valid_d, frame_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state_q <= RX_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      rx_shift_q <= '0;
      byte_stb_q <= 1'b0;
      stop_err_q <= 1'b0;
      as_state_q <= AS_HUNT;
      byte_cnt_q <= '0;
      xor_acc_q  <= '0;
      shadow_q   <= '0;
      to_cnt_q   <= '0;
      ftw        <= FTW_RESET;
      ftw_valid  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      rx_state_q <= rx_state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      rx_shift_q <= rx_shift_d;
      byte_stb_q <= byte_stb_d;
      stop_err_q <= stop_err_d;
      as_state_q <= as_state_d;
      byte_cnt_q <= byte_cnt_d;
      xor_acc_q  <= xor_acc_d;
      shadow_q   <= shadow_d;
      to_cnt_q   <= to_cnt_d;
      ftw        <= ftw_d;
      ftw_valid  <= ftw_valid_d;
      frame_err  <= frame_err_d;
    end
  end

  // Byte receiver: sample mid-bit, return to idle at the stop sample.
  always_comb begin
    rx_state_d = rx_state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    rx_shift_d = rx_shift_q;
    byte_stb_d = 1'b0;
    stop_err_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        bit_cnt_d = '0;
        if (rx_prev && !rx_sync) rx_state_d = RX_START;
      end
      RX_START: begin
        if (bit_cnt_q == CW'(HALF - 1)) begin
          bit_cnt_d  = '0;
          bit_idx_d  = '0;
          rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (bit_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          bit_cnt_d  = '0;
          rx_shift_d = {rx_sync, rx_shift_q[7:1]};
          bit_idx_d  = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (bit_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          bit_cnt_d  = '0;
          byte_stb_d = rx_sync;
          stop_err_d = !rx_sync;
          rx_state_d = RX_IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Frame assembler. ftw_valid / frame_err are single-cycle event strobes with
  // no back-pressure: the consumer must act on ftw in the cycle ftw_valid is high.
  always_comb begin
    as_state_d  = as_state_q;
    byte_cnt_d  = byte_cnt_q;
    xor_acc_d   = xor_acc_q;
    shadow_d    = shadow_q;
    to_cnt_d    = to_cnt_q;
    ftw_d       = ftw;
    ftw_valid_d = 1'b0;
    frame_err_d = 1'b0;
    case (as_state_q)
      AS_HUNT: begin
        to_cnt_d = '0;
        if (byte_stb_q && rx_shift_q == HEADER) begin
          as_state_d = AS_PAYLOAD;
          byte_cnt_d = '0;
          xor_acc_d  = '0;
        end
      end
      AS_PAYLOAD, AS_CHECK: begin
        if (stop_err_q || to_cnt_q == TW'(TO_LIMIT)) begin
          as_state_d  = AS_HUNT;
          frame_err_d = 1'b1;
          to_cnt_d    = '0;
        end else if (byte_stb_q) begin
          to_cnt_d = '0;
          if (as_state_q == AS_PAYLOAD) begin
            shadow_d   = W'({shadow_q, rx_shift_q});
            xor_acc_d  = xor_acc_q ^ rx_shift_q;
            byte_cnt_d = byte_cnt_q + BCW'(1);
            if (byte_cnt_q == BCW'(FTW_BYTES - 1)) as_state_d = AS_CHECK;
          end else begin
            as_state_d = AS_HUNT;
            if (rx_shift_q == xor_acc_q) begin
              ftw_d       = shadow_q;
              ftw_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      default: as_state_d = AS_HUNT;
    endcase
  end

  assign busy = (as_state_q != AS_HUNT);

endmodule

// File: tb/tb_uart_ftw_rx.sv
// Bench for uart_ftw_rx: directed frames from the test plan plus random frames,
// scored against a byte-level model (concatenated payload, XOR checksum).
module tb_uart_ftw_rx;

  localparam int CPB = 48;

  logic        clk;
  logic        rst;
  logic        rx;
  logic [31:0] ftw;
  logic        ftw_valid;
  logic        frame_err;
  logic        busy;

  uart_ftw_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .ftw       (ftw),
    .ftw_valid (ftw_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [31:0] exp_q[$];
  logic [31:0] exp_ftw;
  int n_cmp = 0;
  int n_bad = 0;
  int vcnt = 0, ecnt = 0, busy_cnt = 0;
  int both_cnt = 0, wide_cnt = 0, stray_cnt = 0;
  logic prev_valid = 1'b0, prev_err = 1'b0, prev_rst = 1'b1;
  logic [31:0] prev_ftw = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: pulse counting, ftw scoreboard, protocol rules
  always @(negedge clk) begin
    if (!rst) begin
      if (ftw_valid) begin
        vcnt++;
        if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
        else check("ftw_at_valid", ftw, exp_q.pop_front());
      end
      if (frame_err) ecnt++;
      if (busy) busy_cnt++;
      if (ftw_valid && frame_err) both_cnt++;
      if ((ftw_valid && prev_valid) || (frame_err && prev_err)) wide_cnt++;
      if (ftw !== prev_ftw && !ftw_valid && !prev_rst) stray_cnt++;
    end
    prev_valid = ftw_valid;
    prev_err   = frame_err;
    prev_ftw   = ftw;
    prev_rst   = rst;
  end

  // Driver tasks (all run from posedge + #1)
  task automatic wait_bit();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    for (int i = 0; i < n; i++) wait_bit();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    wait_bit();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_bit();
    end
    rx = stop_ok;
    wait_bit();
    rx = 1'b1;
    if (!stop_ok) wait_bit();
  endtask

  task automatic send_frame(input string tag, input logic [31:0] pay,
                            input logic [7:0] chk, input int gap);
    int v0, e0;
    logic ok;
    ok = (chk == (pay[31:24] ^ pay[23:16] ^ pay[15:8] ^ pay[7:0]));
    send_byte(8'hA5, 1'b1);
    idle_bits(gap);
    for (int i = 3; i >= 0; i--) begin
      send_byte(pay[i*8 +: 8], 1'b1);
      idle_bits(gap);
    end
    v0 = vcnt;
    e0 = ecnt;
    if (ok) exp_q.push_back(pay);
    send_byte(chk, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    if (ok) exp_ftw = pay;
    check({tag, "_valid_cnt"}, 32'(vcnt - v0), ok ? 32'd1 : 32'd0);
    check({tag, "_err_cnt"}, 32'(ecnt - e0), ok ? 32'd0 : 32'd1);
    check({tag, "_ftw"}, ftw, exp_ftw);
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  // Stimulus
  initial begin
    int v0, e0, b0;
    logic [31:0] pay;
    logic [7:0]  chk, noise;
    rst = 1'b1;
    rx  = 1'b1;
    exp_ftw = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ftw", ftw, 32'd0);
    check("reset_valid", {31'd0, ftw_valid}, 32'd0);
    check("reset_err", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    idle_bits(2);

    send_frame("good", 32'h12345678, 8'h08, 0);
    send_frame("bad_chk", 32'h12345678, 8'h09, 0);

    // Short low glitch must not start a byte
    v0 = vcnt; e0 = ecnt; b0 = busy_cnt;
    rx = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rx = 1'b1;
    idle_bits(2);
    check("glitch_valid", 32'(vcnt - v0), 32'd0);
    check("glitch_err", 32'(ecnt - e0), 32'd0);
    check("glitch_busy", 32'(busy_cnt - b0), 32'd0);
    send_byte(8'h55, 1'b1);
    send_frame("after_noise", 32'hCAFEF00D, 8'hCA ^ 8'hFE ^ 8'hF0 ^ 8'h0D, 0);

    // Framing error mid-payload
    v0 = vcnt; e0 = ecnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b0);
    check("stop_err_cnt", 32'(ecnt - e0), 32'd1);
    check("stop_err_valid", 32'(vcnt - v0), 32'd0);
    check("stop_err_busy", {31'd0, busy}, 32'd0);
    check("stop_err_ftw", ftw, exp_ftw);
    send_frame("after_stop_err", 32'h0BADBEEF, 8'h0B ^ 8'hAD ^ 8'hBE ^ 8'hEF, 0);

    // Inter-byte timeout
    v0 = vcnt; e0 = ecnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    check("mid_frame_busy", {31'd0, busy}, 32'd1);
    idle_bits(21);
    check("timeout_err_cnt", 32'(ecnt - e0), 32'd1);
    check("timeout_valid", 32'(vcnt - v0), 32'd0);
    check("timeout_busy", {31'd0, busy}, 32'd0);
    check("timeout_ftw", ftw, exp_ftw);

    // Reset in the middle of payload byte 3
    send_byte(8'hA5, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    rx = 1'b0;
    wait_bit();
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      wait_bit();
    end
    v0 = vcnt; e0 = ecnt;
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_ftw = '0;
    check("midrst_ftw", ftw, 32'd0);
    check("midrst_valid", {31'd0, ftw_valid}, 32'd0);
    check("midrst_err", {31'd0, frame_err}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    idle_bits(2);
    check("midrst_no_pulse", 32'(vcnt - v0 + ecnt - e0), 32'd0);
    send_frame("after_reset", 32'h87654321, 8'h87 ^ 8'h65 ^ 8'h43 ^ 8'h21, 0);

    // Header value inside the payload is plain data
    send_frame("hdr_as_data", 32'hA5A500A5, 8'hA5, 0);

    // Random frames: noise prefix, gaps, occasional checksum corruption
    for (int n = 0; n < 10; n++) begin
      pay = $urandom;
      chk = pay[31:24] ^ pay[23:16] ^ pay[15:8] ^ pay[7:0];
      if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      if ($urandom_range(0, 2) == 0) begin
        noise = 8'($urandom_range(0, 255));
        if (noise == 8'hA5) noise = 8'h5A;
        send_byte(noise, 1'b1);
      end
      send_frame($sformatf("rand%0d", n), pay, chk, $urandom_range(0, 2));
    end

    idle_bits(2);
    check("pulse_exclusive", 32'(both_cnt), 32'd0);
    check("pulse_width", 32'(wide_cnt), 32'd0);
    check("ftw_stray_change", 32'(stray_cnt), 32'd0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
